// File: rtl/pll_rst_seq_if.sv
// ----------------------------------------------------------------------------
// pll_rst_seq_if
//   Bundle between the PLL lock supervisor / reset sequencer and the PLL plus
//   the downstream clock domains it holds in reset.
//
//   Signals
//     pll_lock    PLL LOCK, asynchronous to the sequencer clock
//     pll_rst     PLL RST, active-high
//     ch_rst      per-channel reset, active-high, bit 0 released first
//     ready       all channels released and lock held
//     fault       lock retries exhausted, sticky until reset
//     state       sequencer FSM state (debug)
//     relock_cnt  lock-loss event counter, only present when
//                 PLL_RST_SEQ_RELOCK_CNT_EN is defined
//
//   Modports
//     master  the sequencer (drives resets/status, reads lock)
//     slave   the PLL / domain side (drives lock, reads resets/status)
//
//   Handshake: none. pll_lock is a level that may change at any time; every
//   output is a level that is valid on every clkin1 cycle.
// ----------------------------------------------------------------------------
interface pll_rst_seq_if #(
    parameter int NUM_CH = 2
);
    logic              pll_lock;
    logic              pll_rst;
    logic [NUM_CH-1:0] ch_rst;
    logic              ready;
    logic              fault;
    logic [2:0]        state;
`ifdef PLL_RST_SEQ_RELOCK_CNT_EN
    logic [7:0]        relock_cnt;

    modport master (
        input  pll_lock,
        output pll_rst, ch_rst, ready, fault, state, relock_cnt
    );
    modport slave (
        output pll_lock,
        input  pll_rst, ch_rst, ready, fault, state, relock_cnt
    );
`else
    modport master (
        input  pll_lock,
        output pll_rst, ch_rst, ready, fault, state
    );
    modport slave (
        output pll_lock,
        input  pll_rst, ch_rst, ready, fault, state
    );
`endif
endinterface

// File: rtl/pll_rst_seq.sv
// ----------------------------------------------------------------------------
// pll_rst_seq
//   PLL lock supervisor and downstream reset sequencer, clocked by the PLL
//   reference clock. Pulses the PLL reset, waits for LOCK, qualifies it as
//   stable, then releases the channel resets one by one. A lock loss after
//   qualification re-resets everything; repeated lock timeouts end in a
//   sticky fault.
//
//   Ports
//     clkin1   reference clock (same net as the PLL CLKIN1)
//     rst      synchronous, active-high reset
//     io_bus   pll_rst_seq_if.master: pll_lock in; pll_rst, ch_rst, ready,
//              fault, state (and relock_cnt) out
//
//   Optional feature macro: PLL_RST_SEQ_RELOCK_CNT_EN
//     defined   -> relock_cnt[7:0] counts lock-loss exits from RELEASE/RUN,
//                  saturating at 255, cleared only by rst
//     undefined -> no relock counter
// ----------------------------------------------------------------------------
module pll_rst_seq #(
    parameter int NUM_CH           = 2,
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int CH_GAP_CYC       = 8,
    parameter int MAX_RETRY        = 3
) (
    input  logic          clkin1,
    input  logic          rst,
    pll_rst_seq_if.master io_bus
);
    localparam int PULSE_W = $clog2(RST_PULSE_CYC + 1);
    localparam int TO_W    = $clog2(LOCK_TIMEOUT_CYC + 1);
    localparam int STB_W   = $clog2(LOCK_STABLE_CYC + 1);
    localparam int GAP_W   = $clog2(CH_GAP_CYC + 1);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    // Counters start at 0 on state entry, so "last" is the parameter minus one.
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RST_PULSE_CYC - 1);
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [STB_W-1:0]   STB_LAST   = STB_W'(LOCK_STABLE_CYC - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(CH_GAP_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RST_PLL   = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_STABLE    = 3'd3,
        S_RELEASE   = 3'd4,
        S_RUN       = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    state_t              r_state;
    logic                r_lock_meta;
    logic                r_lock_s;
    logic [NUM_CH-1:0]   r_ch_rst;
    logic [PULSE_W-1:0]  r_pulse_cnt;
    logic [TO_W-1:0]     r_to_cnt;
    logic [STB_W-1:0]    r_stb_cnt;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic [RETRY_W-1:0]  r_retry_cnt;

    state_t              w_state_nxt;
    logic [NUM_CH-1:0]   w_ch_rst_nxt;
    logic [PULSE_W-1:0]  w_pulse_nxt;
    logic [TO_W-1:0]     w_to_nxt;
    logic [STB_W-1:0]    w_stb_nxt;
    logic [GAP_W-1:0]    w_gap_nxt;
    logic [RETRY_W-1:0]  w_retry_nxt;

    // Next-state logic. Per-state counters default to 0 so every state is
    // entered with a cleared count; the owning state advances its own counter.
    always_comb begin
        w_state_nxt  = r_state;
        w_ch_rst_nxt = r_ch_rst;
        w_pulse_nxt  = '0;
        w_to_nxt     = '0;
        w_stb_nxt    = '0;
        w_gap_nxt    = '0;
        w_retry_nxt  = r_retry_cnt;
        case (r_state)
            S_IDLE: begin
                w_ch_rst_nxt = '1;
                w_state_nxt  = S_RST_PLL;
            end
            S_RST_PLL: begin
                w_ch_rst_nxt = '1;
                if (r_pulse_cnt == PULSE_LAST) w_state_nxt = S_WAIT_LOCK;
                else                           w_pulse_nxt = r_pulse_cnt + 1'b1;
            end
            S_WAIT_LOCK: begin
                // Lock is tested first so it beats a coincident timeout.
                if (r_lock_s) begin
                    w_state_nxt = S_STABLE;
                end else if (r_to_cnt == TO_LAST) begin
                    if (r_retry_cnt < RETRY_MAX) begin
                        w_retry_nxt = r_retry_cnt + 1'b1;
                        w_state_nxt = S_RST_PLL;
                    end else begin
                        w_state_nxt = S_FAULT;
                    end
                end else begin
                    w_to_nxt = r_to_cnt + 1'b1;
                end
            end
            S_STABLE: begin
                // A drop beats a coincident stable-count completion.
                if (!r_lock_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                end else if (r_stb_cnt == STB_LAST) begin
                    w_state_nxt  = S_RELEASE;
                    w_ch_rst_nxt = {NUM_CH{1'b1}} << 1;
                end else begin
                    w_stb_nxt = r_stb_cnt + 1'b1;
                end
            end
            S_RELEASE: begin
                // Channels release LSB first by shifting zeros in from bit 0.
                if (!r_lock_s) begin
                    w_state_nxt  = S_RST_PLL;
                    w_ch_rst_nxt = '1;
                end else if (r_ch_rst == '0) begin
                    w_state_nxt = S_RUN;
                    w_retry_nxt = '0;
                end else if (r_gap_cnt == GAP_LAST) begin
                    w_ch_rst_nxt = r_ch_rst << 1;
                end else begin
                    w_gap_nxt = r_gap_cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (!r_lock_s) begin
                    w_state_nxt  = S_RST_PLL;
                    w_ch_rst_nxt = '1;
                end
            end
            S_FAULT: begin
                w_ch_rst_nxt = '1;
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_ch_rst_nxt = '1;
            end
        endcase
    end

    always_ff @(posedge clkin1) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
            r_ch_rst    <= '1;
            r_pulse_cnt <= '0;
            r_to_cnt    <= '0;
            r_stb_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_retry_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_lock_meta <= io_bus.pll_lock;
            r_lock_s    <= r_lock_meta;
            r_ch_rst    <= w_ch_rst_nxt;
            r_pulse_cnt <= w_pulse_nxt;
            r_to_cnt    <= w_to_nxt;
            r_stb_cnt   <= w_stb_nxt;
            r_gap_cnt   <= w_gap_nxt;
            r_retry_cnt <= w_retry_nxt;
        end
    end

`ifdef PLL_RST_SEQ_RELOCK_CNT_EN
    logic [7:0] r_relock_cnt;
    logic       w_lock_loss;

    assign w_lock_loss = ((r_state == S_RELEASE) || (r_state == S_RUN)) && !r_lock_s;

    always_ff @(posedge clkin1) begin
        if (rst)                                     r_relock_cnt <= '0;
        else if (w_lock_loss && (r_relock_cnt != 8'hFF)) r_relock_cnt <= r_relock_cnt + 1'b1;
    end

    assign io_bus.relock_cnt = r_relock_cnt;
`endif

    // pll_rst is held in every state where the PLL is not expected to run.
    assign io_bus.pll_rst = !((r_state == S_WAIT_LOCK) || (r_state == S_STABLE) ||
                              (r_state == S_RELEASE)   || (r_state == S_RUN));
    assign io_bus.ch_rst  = r_ch_rst;
    assign io_bus.ready   = (r_state == S_RUN);
    assign io_bus.fault   = (r_state == S_FAULT);
    assign io_bus.state   = r_state;

endmodule
